// File: rtl/life_gen_scheduler.sv
// Owns the single port of the board RAM. It time-shares that port between draw-engine row reads and an in-place Conway step.
// Build option: define LIFE_WRAP_EN for a toroidal board; when it is undefined, cells beyond the edges are treated as dead.
module life_gen_scheduler #(
    parameter int COLS = 40,
    parameter int ROWS = 31,
    parameter int AW   = 5,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            step,
    input  logic            run,
    input  logic            draw_req,
    input  logic [AW-1:0]   draw_row,
    output logic            draw_gnt,
    output logic            draw_valid,
    output logic [COLS-1:0] draw_data,
    output logic [AW-1:0]   ram_addr,
    output logic [COLS-1:0] ram_wdata,
    output logic            ram_wren,
    input  logic [COLS-1:0] ram_q,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   gen_count
);

`ifdef LIFE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, D_RD, D_DAT, G_RDL, G_RD0, G_RD1, G_WR, G_RDN, G_DONE
    } state_t;

    state_t          r_state, w_next;
    logic            r_pending, r_last_gen;
    logic [COLS-1:0] r_prev, r_cur, r_row0;
    logic [AW-1:0]   r_r;
    logic [CW-1:0]   r_gen_count;

    logic            w_gen_req, w_start;
    logic [COLS-1:0] w_nxt, w_life;
    logic [COLS-1:0] w_pl, w_pr, w_cl, w_cr, w_nl, w_nr;

    // Bit COLS-1 is column 0, so a right shift brings the left neighbour into place.
    function automatic logic [COLS-1:0] sh_r(input logic [COLS-1:0] w);
        return {WRAP & w[0], w[COLS-1:1]};
    endfunction

    function automatic logic [COLS-1:0] sh_l(input logic [COLS-1:0] w);
        return {w[COLS-2:0], WRAP & w[COLS-1]};
    endfunction

    assign w_gen_req = r_pending | step | run;
    assign w_start   = (r_state == IDLE) && (w_next == G_RDL);
    assign w_nxt     = (r_r < AW'(ROWS-1)) ? ram_q : (WRAP ? r_row0 : '0);
    assign gen_count = r_gen_count;

    assign w_pl = sh_r(r_prev);
    assign w_pr = sh_l(r_prev);
    assign w_cl = sh_r(r_cur);
    assign w_cr = sh_l(r_cur);
    assign w_nl = sh_r(w_nxt);
    assign w_nr = sh_l(w_nxt);

    for (genvar i = 0; i < COLS; i++) begin : g_cell
        logic [3:0] w_n;
        assign w_n = {3'b0, w_pl[i]} + {3'b0, r_prev[i]} + {3'b0, w_pr[i]}
                   + {3'b0, w_cl[i]} + {3'b0, w_cr[i]}
                   + {3'b0, w_nl[i]} + {3'b0, w_nxt[i]} + {3'b0, w_nr[i]};
        assign w_life[i] = (w_n == 4'd3) | (r_cur[i] & (w_n == 4'd2));
    end

    always_comb begin
        w_next     = r_state;
        draw_gnt   = 1'b0;
        draw_valid = 1'b0;
        draw_data  = '0;
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_wren   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                // When both sides are requesting, last_gen alternates service between them.
                if (w_gen_req && !(draw_req && r_last_gen)) w_next = G_RDL;
                else if (draw_req)                          w_next = D_RD;
            end
            D_RD: begin
                ram_addr = draw_row;
                draw_gnt = 1'b1;
                w_next   = D_DAT;
            end
            D_DAT: begin
                draw_valid = 1'b1;
                draw_data  = ram_q;
                w_next     = IDLE;
            end
            G_RDL: begin
                busy     = 1'b1;
                ram_addr = AW'(ROWS-1);
                w_next   = G_RD0;
            end
            G_RD0: begin
                busy   = 1'b1;
                w_next = G_RD1;
            end
            G_RD1: begin
                busy     = 1'b1;
                ram_addr = AW'(1);
                w_next   = G_WR;
            end
            G_WR: begin
                busy      = 1'b1;
                ram_wren  = 1'b1;
                ram_addr  = r_r;
                ram_wdata = w_life;
                if (r_r < AW'(ROWS-2))       w_next = G_RDN;
                else if (r_r == AW'(ROWS-2)) w_next = G_WR;
                else                         w_next = G_DONE;
            end
            G_RDN: begin
                busy     = 1'b1;
                ram_addr = r_r + AW'(1);
                w_next   = G_WR;
            end
            G_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_last_gen  <= 1'b0;
            r_prev      <= '0;
            r_cur       <= '0;
            r_row0      <= '0;
            r_r         <= '0;
            r_gen_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_start)   r_pending <= 1'b0;
            else if (step) r_pending <= 1'b1;
            case (r_state)
                D_DAT: r_last_gen <= 1'b0;
                G_RD0: r_prev <= WRAP ? ram_q : '0;
                G_RD1: begin
                    r_cur  <= ram_q;
                    r_row0 <= ram_q;
                    r_r    <= '0;
                end
                // The window slides down one row; row r has already been written back.
                G_WR: begin
                    r_prev <= r_cur;
                    r_cur  <= w_nxt;
                    r_r    <= r_r + AW'(1);
                end
                G_DONE: begin
                    r_gen_count <= r_gen_count + CW'(1);
                    r_last_gen  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Directed bench for life_gen_scheduler. It uses a behavioural single-port board RAM and a preload port for setting up boards.
module tb_life_gen_scheduler;

    localparam int COLS = 40;
    localparam int ROWS = 31;
    localparam int AW   = 5;
    localparam int CW   = 16;

    localparam logic [COLS-1:0] COL20   = 40'h00_0008_0000;
    localparam logic [COLS-1:0] ROW10_E = 40'h00_001C_0000;
    localparam logic [COLS-1:0] COL10   = 40'h00_2000_0000;
    localparam logic [COLS-1:0] ROW5_E  = 40'h00_7000_0000;
    localparam logic [COLS-1:0] EDGES   = 40'h80_0000_0001;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            step, run, draw_req;
    logic [AW-1:0]   draw_row;
    logic            draw_gnt, draw_valid;
    logic [COLS-1:0] draw_data;
    logic [AW-1:0]   ram_addr;
    logic [COLS-1:0] ram_wdata;
    logic            ram_wren;
    logic [COLS-1:0] ram_q;
    logic            busy, done;
    logic [CW-1:0]   gen_count;

    logic [COLS-1:0] mem [0:ROWS-1];
    logic            pl_we;
    logic [AW-1:0]   pl_addr;
    logic [COLS-1:0] pl_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we)         mem[pl_addr] <= pl_data;
        else if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    life_gen_scheduler #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .step(step), .run(run),
        .draw_req(draw_req), .draw_row(draw_row), .draw_gnt(draw_gnt),
        .draw_valid(draw_valid), .draw_data(draw_data), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy), .done(done), .gen_count(gen_count)
    );

    task automatic do_reset();
        reset_n = 1'b0; step = 1'b0; run = 1'b0; draw_req = 1'b0; draw_row = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic load_row(input int r, input logic [COLS-1:0] d);
        @(posedge clk);
        #1 pl_we = 1'b1; pl_addr = AW'(r); pl_data = d;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic clear_board();
        for (int r = 0; r < ROWS; r++) load_row(r, '0);
    endtask

    // Pulses step once and counts busy cycles until the block goes idle again.
    task automatic run_gen(output int ncyc, output int ndone, output int done_at);
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        ncyc = 0; ndone = 0; done_at = -1;
        while (busy && ncyc < 200) begin
            ncyc++;
            if (done) begin ndone++; done_at = ncyc; end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, done, ram_wren, draw_gnt, draw_valid} !== 5'b0 || gen_count !== '0 ||
            ram_addr !== '0 || ram_wdata !== '0 || draw_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b wren=%b gnt=%b valid=%b cnt=%0d addr=%0d wdata=%h ddata=%h, need all 0",
                     busy, done, ram_wren, draw_gnt, draw_valid, gen_count, ram_addr, ram_wdata, draw_data);
        end
    endtask

    task automatic test_blinker();
        int n, d, at, bad;
        clear_board();
        load_row(9, COL20); load_row(10, COL20); load_row(11, COL20);
        run_gen(n, d, at);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL blinker_busy_len: got %0d need 64", n); end
        checks++;
        if (d !== 1 || at !== 64) begin errors++; $display("FAIL blinker_done: count %0d at %0d need 1 at 64", d, at); end
        checks++;
        if (gen_count !== 16'd1) begin errors++; $display("FAIL blinker_gen_count: got %0d need 1", gen_count); end
        checks++;
        if (mem[10] !== ROW10_E) begin errors++; $display("FAIL blinker_row10: got %h need %h", mem[10], ROW10_E); end
        checks++;
        if (mem[9] !== '0 || mem[11] !== '0) begin
            errors++; $display("FAIL blinker_rows9_11: got %h %h need 0", mem[9], mem[11]);
        end
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (r != 10 && mem[r] !== '0) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL blinker_rest_zero: %0d nonzero rows, need 0", bad); end
    endtask

    task automatic test_corners();
        int n, d, at, bad;
        logic [COLS-1:0] exp_edge;
`ifdef LIFE_WRAP_EN
        exp_edge = EDGES;
`else
        exp_edge = '0;
`endif
        clear_board();
        load_row(0, EDGES); load_row(ROWS-1, EDGES);
        run_gen(n, d, at);
        checks++;
        if (gen_count !== 16'd2 || n !== 64) begin
            errors++; $display("FAIL corners_gen: cnt %0d len %0d need 2 and 64", gen_count, n);
        end
        checks++;
        if (mem[0] !== exp_edge) begin errors++; $display("FAIL corners_row0: got %h need %h", mem[0], exp_edge); end
        checks++;
        if (mem[ROWS-1] !== exp_edge) begin errors++; $display("FAIL corners_row30: got %h need %h", mem[ROWS-1], exp_edge); end
        bad = 0;
        for (int r = 1; r < ROWS-1; r++) if (mem[r] !== '0) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL corners_middle_zero: %0d nonzero rows, need 0", bad); end
    endtask

    task automatic test_arbitration();
        int cyc, done_c, gnt_c, val_c, clash;
        logic [COLS-1:0] vdata;
        do_reset();
        clear_board();
        load_row(4, COL10); load_row(5, COL10); load_row(6, COL10);
        @(posedge clk);
        #1 step = 1'b1; draw_req = 1'b1; draw_row = 5'd5;
        @(posedge clk);
        #1 step = 1'b0;
        checks++;
        if (busy !== 1'b1 || draw_gnt !== 1'b0) begin
            errors++; $display("FAIL arb_gen_first: busy=%b gnt=%b need 1 0", busy, draw_gnt);
        end
        cyc = 1; done_c = -1; gnt_c = -1; val_c = -1; clash = 0; vdata = '0;
        while (cyc < 200 && val_c < 0) begin
            if (done) done_c = cyc;
            if (done && draw_gnt) clash++;
            if (draw_gnt) begin gnt_c = cyc; draw_req = 1'b0; end
            if (draw_valid) begin val_c = cyc; vdata = draw_data; end
            @(posedge clk);
            #1 cyc++;
        end
        draw_req = 1'b0;
        checks++;
        if (done_c !== 64 || gnt_c !== done_c + 2) begin
            errors++; $display("FAIL arb_gnt_timing: done@%0d gnt@%0d need 64 and 66", done_c, gnt_c);
        end
        checks++;
        if (val_c !== gnt_c + 1 || vdata !== ROW5_E) begin
            errors++; $display("FAIL arb_draw_data: valid@%0d data %h need @%0d data %h", val_c, vdata, gnt_c + 1, ROW5_E);
        end
        checks++;
        if (clash !== 0 || gen_count !== 16'd1) begin
            errors++; $display("FAIL arb_misc: clash %0d cnt %0d need 0 and 1", clash, gen_count);
        end
    endtask

    task automatic test_back_to_back();
        int nbusy, ndone, done1, rise2;
        logic pbusy;
        nbusy = 0; ndone = 0; done1 = -1; rise2 = -1; pbusy = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step = (c == 0 || c == 5 || c == 10 || c == 30);
            @(posedge clk);
            #1;
            if (busy) nbusy++;
            if (done) begin ndone++; if (done1 < 0) done1 = c; end
            if (busy && !pbusy && done1 >= 0 && rise2 < 0) rise2 = c;
            pbusy = busy;
        end
        step = 1'b0;
        checks++;
        if (ndone !== 2 || nbusy !== 128) begin
            errors++; $display("FAIL b2b_count: dones %0d busy %0d need 2 and 128", ndone, nbusy);
        end
        checks++;
        if (done1 !== 63 || rise2 !== 65) begin
            errors++; $display("FAIL b2b_timing: done1@%0d restart@%0d need 63 and 65", done1, rise2);
        end
        checks++;
        if (gen_count !== 16'd3) begin errors++; $display("FAIL b2b_gen_count: got %0d need 3", gen_count); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(posedge clk);
        #1 step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, ram_wren, draw_gnt, draw_valid} !== 5'b0 || gen_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b wren=%b gnt=%b valid=%b cnt=%0d need all 0",
                     busy, done, ram_wren, draw_gnt, draw_valid, gen_count);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1 if (busy || done || ram_wren) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_restart: %0d active cycles need 0", seen); end
    endtask

    task automatic test_draw_idle();
        int wr;
        load_row(5, EDGES);
        @(posedge clk);
        #1 draw_req = 1'b1; draw_row = 5'd5;
        @(posedge clk);
        #1 wr = int'(ram_wren);
        checks++;
        if (draw_gnt !== 1'b1 || ram_addr !== 5'd5 || draw_valid !== 1'b0) begin
            errors++; $display("FAIL draw_gnt: gnt=%b addr=%0d valid=%b need 1 5 0", draw_gnt, ram_addr, draw_valid);
        end
        draw_req = 1'b0;
        @(posedge clk);
        #1 wr += int'(ram_wren);
        checks++;
        if (draw_valid !== 1'b1 || draw_data !== EDGES) begin
            errors++; $display("FAIL draw_valid: valid=%b data=%h need 1 %h", draw_valid, draw_data, EDGES);
        end
        @(posedge clk);
        #1 wr += int'(ram_wren);
        checks++;
        if (wr !== 0 || draw_valid !== 1'b0 || draw_gnt !== 1'b0) begin
            errors++; $display("FAIL draw_after: wren_cycles=%0d valid=%b gnt=%b need 0 0 0", wr, draw_valid, draw_gnt);
        end
    endtask

    initial begin
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        test_reset();
        test_blinker();
        test_corners();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        test_draw_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
